// File: rtl/bus_breakout_seq.sv
// bus_breakout_seq: nibble-pair sequencer into a valid/ready 6-bit merged word; optional out_parity via BUS_BREAKOUT_SEQ_PARITY_EN
module bus_breakout_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [5:0]       out_data,
    input  logic             out_ready,
    output logic             out_partial,
`ifdef BUS_BREAKOUT_SEQ_PARITY_EN
    output logic [CNT_W-1:0] word_count,
    output logic             out_parity
`else
    output logic [CNT_W-1:0] word_count
`endif
);
    typedef enum logic [1:0] {S_LO, S_HI, S_OUT} state_t;
    state_t state, state_nxt;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [5:0] merged;
    logic in_hs;
    logic out_hs;
    assign out_valid = state == S_OUT;
    assign out_hs = out_valid && out_ready;
    assign in_hs = in_valid && in_ready;
    assign hi = in_hs ? in_data : 4'h0;
    assign merged = {hi[3:2], hi[1] & lo[3], hi[0] & lo[2], lo[1:0]};
    always_comb begin
        in_ready = rst_n && (state != S_OUT || out_ready);
        state_nxt = state;
        if (state == S_LO)
            state_nxt = in_hs ? S_HI : S_LO;
        else if (state == S_HI)
            state_nxt = (in_hs || flush) ? S_OUT : S_HI;
        else if (out_hs)
            state_nxt = in_hs ? S_HI : S_LO;
    end
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_LO;
        else
            state <= state_nxt;
    end
    // A flush reuses the merge path with hi forced to zero (hi is 0 when no nibble is taken)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo          <= 4'h0;
            out_data    <= 6'h00;
            out_partial <= 1'b0;
            word_count  <= '0;
        end else begin
            if (in_hs && state != S_HI)
                lo <= in_data;
            if (state == S_HI && (in_hs || flush)) begin
                out_data    <= merged;
                out_partial <= !in_hs;
            end
            if (out_hs)
                word_count <= word_count + 1'b1;
        end
    end
`ifdef BUS_BREAKOUT_SEQ_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            out_parity <= 1'b0;
        else if (state == S_HI && (in_hs || flush))
            out_parity <= ^merged;
    end
`endif
endmodule

// File: tb/tb_bus_breakout_seq.sv
// tb_bus_breakout_seq: directed and model-checked bench for bus_breakout_seq (default and CNT_W=2 instances)
module tb_bus_breakout_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic flush = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid, out_partial;
    logic [5:0] out_data;
    logic [7:0] word_count;
    logic in_ready2, out_valid2, out_partial2;
    logic [5:0] out_data2;
    logic [1:0] word_count2;
`ifdef BUS_BREAKOUT_SEQ_PARITY_EN
    logic out_parity, out_parity2;
`endif
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    bus_breakout_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .out_partial(out_partial),
`ifdef BUS_BREAKOUT_SEQ_PARITY_EN
        .out_parity(out_parity),
`endif
        .word_count(word_count)
    );

    bus_breakout_seq #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .flush(flush), .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready),
        .out_partial(out_partial2),
`ifdef BUS_BREAKOUT_SEQ_PARITY_EN
        .out_parity(out_parity2),
`endif
        .word_count(word_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a pending lo nibble, an outstanding word, a running word total
    bit m_have_lo = 1'b0;
    logic [3:0] m_lo = 4'h0;
    bit m_ov = 1'b0;
    logic [5:0] m_data = 6'h00;
    bit m_part = 1'b0;
    int m_cnt = 0;

    function automatic logic [5:0] merge(input logic [3:0] lo, input logic [3:0] hi);
        int w;
        w = ((int'(hi) << 2) & (32'h30 | (int'(lo) & 32'hC))) | (int'(lo) & 32'h3);
        return w[5:0];
    endfunction

    always @(posedge clk) begin
        bit rdy, acc;
        if (!rst_n) begin
            m_have_lo = 1'b0; m_lo = 4'h0; m_ov = 1'b0;
            m_data = 6'h00; m_part = 1'b0; m_cnt = 0;
        end else begin
            rdy = !m_ov || out_ready;
            acc = in_valid && rdy;
            if (m_ov && out_ready) begin
                m_ov = 1'b0;
                m_cnt++;
            end
            if (acc && m_have_lo) begin
                m_data = merge(m_lo, in_data); m_part = 1'b0; m_ov = 1'b1; m_have_lo = 1'b0;
            end else if (acc) begin
                m_lo = in_data; m_have_lo = 1'b1;
            end else if (flush && m_have_lo) begin
                m_data = merge(m_lo, 4'h0); m_part = 1'b1; m_ov = 1'b1; m_have_lo = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, rst_n && (!m_ov || out_ready));
            chk("out_valid", out_valid, m_ov);
            chk("out_data", out_data, m_data);
            chk("out_partial", out_partial, m_part);
            chk("word_count", word_count, m_cnt % 256);
            chk("word_count_w2", word_count2, m_cnt % 4);
            chk("out_data_w2", out_data2, m_data);
`ifdef BUS_BREAKOUT_SEQ_PARITY_EN
            chk("out_parity", out_parity, ^m_data);
`endif
        end
    end

    task automatic cyc(input logic v, input logic [3:0] d, input logic f, input logic r);
        in_valid = v; in_data = d; flush = f; out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(0, 4'h0, 0, 0);
        cyc(0, 4'h0, 0, 0);
        chk_en = 1'b1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 6'h00);
        chk("reset_count", word_count, 0);
        rst_n = 1'b1;
        // basic merge
        cyc(1, 4'hB, 0, 1);
        chk("basic_no_early_valid", out_valid, 0);
        cyc(1, 4'h6, 0, 1);
        chk("basic_valid", out_valid, 1);
        chk("basic_data", out_data, 6'h1B);
        chk("basic_partial", out_partial, 0);
        chk("model_pin_basic", m_data, 6'h1B);
        cyc(0, 4'h0, 0, 1);
        chk("basic_count", word_count, 1);
        // flush ignored in S_LO, then honoured in S_HI
        cyc(0, 4'h0, 1, 1);
        chk("flush_slo_ignored", out_valid, 0);
        cyc(1, 4'hF, 0, 1);
        cyc(0, 4'h0, 1, 1);
        chk("flush_valid", out_valid, 1);
        chk("flush_data", out_data, 6'h03);
        chk("flush_partial", out_partial, 1);
        cyc(0, 4'h0, 0, 1);
        chk("flush_count", word_count, 2);
        // back-pressure: three stalled cycles then one handshake
        cyc(1, 4'hF, 0, 0);
        cyc(1, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_data_held", out_data, 6'h3F);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_count", word_count, 2);
            if (i < 2) cyc(1, 4'h5, 0, 0);
        end
        cyc(0, 4'h0, 0, 1);
        chk("bp_single_hs", word_count, 3);
        chk("bp_released", out_valid, 0);
        // back-to-back: lo of the next word taken in the S_OUT cycle
        cyc(1, 4'hF, 0, 1);
        cyc(1, 4'hF, 0, 1);
        chk("b2b_w1", out_data, 6'h3F);
        cyc(1, 4'h0, 0, 1);
        chk("b2b_gap_valid", out_valid, 0);
        chk("b2b_gap_count", word_count, 4);
        cyc(1, 4'h0, 0, 1);
        chk("b2b_w2_valid", out_valid, 1);
        chk("b2b_w2", out_data, 6'h00);
        cyc(0, 4'h0, 0, 1);
        chk("wrap_w2_count", word_count2, 1);
        chk("model_pin_count", m_cnt, 5);
        // nibble beats flush in S_HI
        cyc(1, 4'hB, 0, 1);
        cyc(1, 4'h6, 1, 1);
        chk("collide_data", out_data, 6'h1B);
        chk("collide_partial", out_partial, 0);
        cyc(0, 4'h0, 0, 1);
        // reset with a lo nibble pending
        cyc(1, 4'hA, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready_low", in_ready, 0);
        cyc(0, 4'h0, 0, 1);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_count", word_count, 0);
        rst_n = 1'b1;
        cyc(1, 4'h3, 0, 1);
        cyc(1, 4'hC, 0, 1);
        chk("rst_clean_data", out_data, 6'h33);
        cyc(0, 4'h0, 0, 1);
        // 255 more words to wrap the 8-bit counter to 0
        for (int i = 0; i < 255; i++) begin
            cyc(1, 4'($urandom_range(15)), 0, 1);
            cyc(1, 4'($urandom_range(15)), 0, 1);
        end
        cyc(0, 4'h0, 0, 1);
        chk("wrap8_count", word_count, 0);
        // random traffic with stalls and flushes, checked by the model
        for (int i = 0; i < 200; i++)
            cyc(1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        cyc(0, 4'h0, 0, 1);
        cyc(0, 4'h0, 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
